// File: rtl/rc4_core_scheduler.sv
// rc4_core_scheduler
// Hands candidate RC4 keys from a shared range to NUM_CORES decrypt cores
// with round-robin arbitration, tracks which cores hold an unchecked key,
// and latches the first reported match (lowest core index wins ties).
module rc4_core_scheduler #(
   parameter int NUM_CORES = 4,
   parameter int KEY_W     = 22,
   parameter int IDX_W     = $clog2(NUM_CORES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [KEY_W-1:0]     key_lo,
   input  logic [KEY_W-1:0]     key_hi,
   input  logic [NUM_CORES-1:0] core_req,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_match,
   output logic [NUM_CORES-1:0] core_gnt,
   output logic [KEY_W-1:0]     core_key,
   output logic                 stop_all,
   output logic                 found,
   output logic [KEY_W-1:0]     found_key,
   output logic [IDX_W-1:0]     found_core,
   output logic                 exhausted,
   output logic                 busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FOUND,
      S_EXHAUSTED
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   // One extra bit so issuing the all-ones key never wraps back to zero.
   logic [KEY_W:0]       r_next_key;
   logic [KEY_W-1:0]     r_key_hi_q;
   logic [NUM_CORES-1:0] r_outstanding;
   logic [IDX_W-1:0]     r_rr_ptr;
   logic [KEY_W-1:0]     r_issued_key [NUM_CORES];
   logic [NUM_CORES-1:0] r_core_gnt;
   logic [KEY_W-1:0]     r_core_key;
   logic [KEY_W-1:0]     r_found_key;
   logic [IDX_W-1:0]     r_found_core;

   logic [NUM_CORES-1:0] w_eligible;
   logic [NUM_CORES-1:0] w_done_v;
   logic [NUM_CORES-1:0] w_match_v;
   logic [NUM_CORES-1:0] w_remaining;
   logic [NUM_CORES-1:0] w_gnt_onehot;
   logic [NUM_CORES-1:0] w_out_next;
   logic                 w_pick_valid;
   logic [IDX_W-1:0]     w_pick_idx;
   logic [IDX_W-1:0]     w_rr_next;
   logic                 w_match_any;
   logic [IDX_W-1:0]     w_match_idx;
   logic                 w_last_key;
   logic                 w_load;
   logic                 w_grant;
   logic                 w_latch_found;

   // Round-robin pick of the first eligible core and lowest-index match.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_eligible   = core_req & ~r_outstanding;
      w_done_v     = core_done & r_outstanding;   // done from an idle core is ignored
      w_match_v    = w_done_v & core_match;
      w_pick_valid = 1'b0;
      w_pick_idx   = '0;
      w_rr_next    = '0;
      // Walk offsets downward so the smallest offset from the pointer wins.
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         int j;
         j = (int'(r_rr_ptr) + k) % NUM_CORES;
         if (w_eligible[j]) begin
            w_pick_valid = 1'b1;
            w_pick_idx   = IDX_W'(j);
            w_rr_next    = IDX_W'((j + 1) % NUM_CORES);
         end
      end
      w_match_any = |w_match_v;
      w_match_idx = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (w_match_v[i]) w_match_idx = IDX_W'(i);
      end
   end

   assign w_last_key   = (r_next_key == {1'b0, r_key_hi_q});
   assign w_remaining  = r_outstanding & ~w_done_v;
   assign w_gnt_onehot = w_grant ? (NUM_CORES'(1) << w_pick_idx) : '0;
   assign w_out_next   = w_remaining | w_gnt_onehot;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   // Next-state and datapath control; a match always beats a grant.
   always_comb begin
      w_state_next  = r_state;
      w_load        = 1'b0;
      w_grant       = 1'b0;
      w_latch_found = 1'b0;
      case (r_state)
         S_IDLE, S_FOUND, S_EXHAUSTED: begin
            if (start) begin
               w_load       = 1'b1;
               w_state_next = (key_lo > key_hi) ? S_EXHAUSTED : S_RUN;
            end
         end
         S_RUN: begin
            if (w_match_any) begin
               w_latch_found = 1'b1;
               w_state_next  = S_FOUND;
            end else if (w_pick_valid) begin
               w_grant = 1'b1;
               if (w_last_key) w_state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_match_any) begin
               w_latch_found = 1'b1;
               w_state_next  = S_FOUND;
            end else if (w_remaining == '0) begin
               w_state_next = S_EXHAUSTED;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Key counter, outstanding tracking, grant registers and match capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_next_key    <= '0;
         r_key_hi_q    <= '0;
         r_outstanding <= '0;
         r_rr_ptr      <= '0;
         r_core_gnt    <= '0;
         r_core_key    <= '0;
         r_found_key   <= '0;
         r_found_core  <= '0;
         // NOTE: the issued-key table is only NUM_CORES registers and feeds found_key, so it is reset like any other flop.
         for (int i = 0; i < NUM_CORES; i++) r_issued_key[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
         r_core_gnt <= '0;
         r_core_key <= '0;
         if (w_load) begin
            r_next_key    <= {1'b0, key_lo};
            r_key_hi_q    <= key_hi;
            r_outstanding <= '0;
            r_found_key   <= '0;
            r_found_core  <= '0;
         end else begin
            r_outstanding <= w_out_next;
         end
         if (w_grant) begin
            r_core_gnt               <= w_gnt_onehot;
            r_core_key               <= r_next_key[KEY_W-1:0];
            r_issued_key[w_pick_idx] <= r_next_key[KEY_W-1:0];
            r_next_key               <= r_next_key + 1'b1;
            r_rr_ptr                 <= w_rr_next;
         end
         if (w_latch_found) begin
            r_found_key  <= r_issued_key[w_match_idx];
            r_found_core <= w_match_idx;
         end
      end
   end

   assign core_gnt   = r_core_gnt;
   assign core_key   = r_core_key;
   assign found_key  = r_found_key;
   assign found_core = r_found_core;
   assign found      = (r_state == S_FOUND);
   assign stop_all   = (r_state == S_FOUND);
   assign exhausted  = (r_state == S_EXHAUSTED);
   assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_rc4_core_scheduler.sv
// Testbench for rc4_core_scheduler: behavioural cores answer grants after a
// per-core latency; expected grants are queued when each search is started
// and compared as the scheduler issues them.
module tb_rc4_core_scheduler;

   localparam int NC = 4;
   localparam int KW = 22;

   typedef struct {
      int            core;
      logic [KW-1:0] key;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          start;
   logic [KW-1:0] key_lo;
   logic [KW-1:0] key_hi;
   logic [NC-1:0] c_req;
   logic [NC-1:0] c_done;
   logic [NC-1:0] c_match;
   logic [NC-1:0] core_gnt;
   logic [KW-1:0] core_key;
   logic          stop_all;
   logic          found;
   logic [KW-1:0] found_key;
   logic [1:0]    found_core;
   logic          exhausted;
   logic          busy;

   rc4_core_scheduler #(.NUM_CORES(NC), .KEY_W(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .key_lo(key_lo), .key_hi(key_hi),
      .core_req(c_req), .core_done(c_done), .core_match(c_match),
      .core_gnt(core_gnt), .core_key(core_key), .stop_all(stop_all),
      .found(found), .found_key(found_key), .found_core(found_core),
      .exhausted(exhausted), .busy(busy)
   );

   int            n_checks = 0;
   int            n_fails  = 0;
   int            n_grants = 0;
   int            cyc      = 0;
   int            start_cyc;
   int            last_done_cyc  = -10;
   int            last_match_cyc = -10;
   int            m_rr = 0;
   exp_t          sb[$];

   bit            c_en   [NC];
   bit            c_hold [NC];
   bit            c_men  [NC];
   int            c_lat  [NC];
   logic [KW-1:0] c_mkey [NC];
   bit            c_busy [NC];
   int            c_cnt  [NC];
   logic [KW-1:0] c_key  [NC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the grants a round-robin arbiter must produce for the enabled cores.
   task automatic push_grants(input logic [NC-1:0] mask, input logic [KW-1:0] first, input int count);
      logic [KW-1:0] k;
      exp_t          e;
      int            c;
      k = first;
      for (int n = 0; n < count; n++) begin
         c = -1;
         for (int s = 0; s < NC; s++) begin
            int j;
            j = (m_rr + s) % NC;
            if (c < 0 && mask[j]) c = j;
         end
         e.core = c;
         e.key  = k;
         sb.push_back(e);
         m_rr = (c + 1) % NC;
         k++;
      end
   endtask

   task automatic config_cores(input logic [NC-1:0] en, input logic [NC-1:0] hold, input int lat);
      @(negedge clk);
      for (int i = 0; i < NC; i++) begin
         c_en[i]   = 1'b0;
         c_men[i]  = 1'b0;
         c_hold[i] = hold[i];
         c_lat[i]  = lat;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < NC; i++) c_en[i] = en[i];
   endtask

   task automatic do_start(input logic [KW-1:0] lo, input logic [KW-1:0] hi);
      @(negedge clk);
      key_lo    = lo;
      key_hi    = hi;
      start     = 1'b1;
      start_cyc = cyc + 1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // sel 0 waits for found, sel 1 for exhausted; returns the cycle it was seen.
   task automatic wait_flag(input int sel, input int budget, output int seen);
      seen = -1;
      for (int n = 0; n < budget; n++) begin
         if ((sel == 0 && found) || (sel == 1 && exhausted)) begin
            seen = cyc;
            break;
         end
         @(negedge clk);
      end
      check((sel == 0) ? "found_timeout" : "exhausted_timeout", 64'(seen >= 0), 1);
   endtask

   // Behavioural decrypt cores.
   initial begin
      c_req   = '0;
      c_done  = '0;
      c_match = '0;
      for (int i = 0; i < NC; i++) begin
         c_en[i] = 1'b0; c_busy[i] = 1'b0; c_cnt[i] = 0; c_key[i] = '0;
         c_hold[i] = 1'b0; c_men[i] = 1'b0; c_lat[i] = 3; c_mkey[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NC; i++) begin
            if (core_gnt[i]) check("regrant_while_busy", 64'(c_busy[i]), 0);
            if (!rst || !c_en[i] || stop_all) begin
               c_req[i] = 1'b0; c_done[i] = 1'b0; c_match[i] = 1'b0; c_busy[i] = 1'b0;
            end else if (c_done[i]) begin
               c_done[i] = 1'b0; c_match[i] = 1'b0; c_busy[i] = 1'b0; c_req[i] = 1'b1;
            end else if (c_busy[i]) begin
               if (c_cnt[i] == 0) begin
                  c_done[i]     = 1'b1;
                  c_match[i]    = c_men[i] && (c_key[i] == c_mkey[i]);
                  last_done_cyc = cyc;
                  if (c_match[i]) last_match_cyc = cyc;
               end else begin
                  c_cnt[i]--;
               end
            end else if (core_gnt[i]) begin
               c_busy[i] = 1'b1;
               c_key[i]  = core_key;
               c_cnt[i]  = c_lat[i] - 1;
               c_req[i]  = c_hold[i];
            end else begin
               c_req[i] = 1'b1;
            end
         end
      end
   end

   // Grant monitor: every grant must be the next queued expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (core_gnt != '0) begin
            n_grants++;
            check("grant_expected", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("grant_core", 64'(core_gnt), 64'(4'b0001 << e.core));
               check("grant_key", 64'(core_key), 64'(e.key));
            end
            check("grant_while_found", 64'(found), 0);
         end
      end
   end

   initial begin
      int seen;
      int g0;
      rst    = 1'b0;
      start  = 1'b0;
      key_lo = '0;
      key_hi = '0;
      #1;
      check("reset_outputs", 64'({core_gnt, core_key, stop_all, found, found_key, found_core, exhausted, busy}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // 1: 0x10..0x17, four cores, no match.
      config_cores(4'hF, 4'h0, 3);
      g0 = n_grants;
      push_grants(4'hF, 22'h10, 8);
      do_start(22'h10, 22'h17);
      check("t1_busy", 64'(busy), 1);
      wait_flag(1, 100, seen);
      check("t1_exhausted_latency", 64'(seen), 64'(last_done_cyc + 1));
      check("t1_found", 64'(found), 0);
      check("t1_busy_after", 64'(busy), 0);
      check("t1_grants", 64'(n_grants - g0), 8);
      check("t1_sb_empty", 64'(sb.size()), 0);

      // 2: same range, core 2 matches key 0x12; the grant in the match cycle is suppressed.
      config_cores(4'hF, 4'h0, 3);
      c_men[2]  = 1'b1;
      c_mkey[2] = 22'h12;
      g0 = n_grants;
      push_grants(4'hF, 22'h10, 5);
      do_start(22'h10, 22'h17);
      wait_flag(0, 100, seen);
      check("t2_found_latency", 64'(seen), 64'(last_match_cyc + 1));
      check("t2_stop_all", 64'(stop_all), 1);
      check("t2_found_key", 64'(found_key), 22'h12);
      check("t2_found_core", 64'(found_core), 2);
      check("t2_exhausted", 64'(exhausted), 0);
      repeat (8) @(negedge clk);
      check("t2_found_sticky", 64'(found), 1);
      check("t2_grants", 64'(n_grants - g0), 5);
      check("t2_sb_empty", 64'(sb.size()), 0);

      // 3: cores 1 and 3 match in the same cycle (during DRAIN); core 1 wins.
      config_cores(4'b1010, 4'h0, 3);
      c_lat[1] = 4;  c_men[1] = 1'b1; c_mkey[1] = 22'h20;
      c_lat[3] = 3;  c_men[3] = 1'b1; c_mkey[3] = 22'h21;
      g0 = n_grants;
      push_grants(4'b1010, 22'h20, 2);
      do_start(22'h20, 22'h21);
      wait_flag(0, 100, seen);
      check("t3_found_latency", 64'(seen), 64'(last_match_cyc + 1));
      check("t3_found_core", 64'(found_core), 1);
      check("t3_found_key", 64'(found_key), 22'h20);
      check("t3_grants", 64'(n_grants - g0), 2);

      // 4: key_lo > key_hi goes straight to EXHAUSTED with no grants.
      config_cores(4'hF, 4'h0, 3);
      g0 = n_grants;
      do_start(22'd5, 22'd4);
      wait_flag(1, 20, seen);
      check("t4_exhausted_immediate", 64'(seen), 64'(start_cyc));
      check("t4_found_cleared", 64'(found), 0);
      repeat (6) @(negedge clk);
      check("t4_grants", 64'(n_grants - g0), 0);

      // 5: single key at the top of the key space; must not wrap.
      config_cores(4'hF, 4'h0, 3);
      g0 = n_grants;
      push_grants(4'hF, 22'h3FFFFF, 1);
      do_start(22'h3FFFFF, 22'h3FFFFF);
      wait_flag(1, 100, seen);
      check("t5_exhausted_latency", 64'(seen), 64'(last_done_cyc + 1));
      repeat (10) @(negedge clk);
      check("t5_grants", 64'(n_grants - g0), 1);
      check("t5_sb_empty", 64'(sb.size()), 0);

      // 6: only core 0, holding its request while busy.
      config_cores(4'b0001, 4'b0001, 10);
      g0 = n_grants;
      push_grants(4'b0001, 22'h30, 3);
      do_start(22'h30, 22'h32);
      wait_flag(1, 200, seen);
      check("t6_exhausted_latency", 64'(seen), 64'(last_done_cyc + 1));
      check("t6_grants", 64'(n_grants - g0), 3);
      check("t6_sb_empty", 64'(sb.size()), 0);

      // 7: reset mid-RUN, then a clean restart.
      config_cores(4'hF, 4'h0, 3);
      g0 = n_grants;
      push_grants(4'hF, 22'h40, 3);
      do_start(22'h40, 22'h4F);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("t7_reset_outputs", 64'({core_gnt, core_key, stop_all, found, found_key, found_core, exhausted, busy}), 0);
      check("t7_grants_before_reset", 64'(n_grants - g0), 3);
      m_rr = 0;
      repeat (2) @(negedge clk);
      check("t7_held_in_reset", 64'({core_gnt, busy, exhausted}), 0);
      rst = 1'b1;
      g0 = n_grants;
      push_grants(4'hF, 22'h50, 4);
      do_start(22'h50, 22'h53);
      wait_flag(1, 100, seen);
      check("t7_exhausted_latency", 64'(seen), 64'(last_done_cyc + 1));
      check("t7_grants", 64'(n_grants - g0), 4);
      check("t7_sb_empty", 64'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/rc4_core_scheduler.md
# rc4_core_scheduler

Work scheduler for the parallel RC4 key-search array. It owns the shared key-space counter, hands one candidate key at a time to whichever decrypt core requests work (round-robin), and tracks which cores are still busy. It detects the first core reporting a plaintext match, latches the winning key and core index, and broadcasts `stop_all`. It sits between the top-level control (start, key range) and the NUM_CORES per-core decrypt/check pipelines.

## Interface
- `NUM_CORES`, default 4: number of decrypt cores; must be ≥ 2.
- `KEY_W`, default 22: candidate key width.
- `IDX_W`, default $clog2(NUM_CORES): core index width.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a search (accepted in IDLE, FOUND, EXHAUSTED).
- `key_lo`  in  KEY_W  first key of the range; sampled on `start`.
- `key_hi`  in  KEY_W  last key of the range, inclusive; sampled on `start`.
- `core_req`  in  NUM_CORES  per-core work request; level, held until granted.
- `core_done`  in  NUM_CORES  per-core single-cycle pulse: the issued key finished checking.
- `core_match`  in  NUM_CORES  per-core match flag; qualified by `core_done`.
- `core_gnt`  out  NUM_CORES  one-hot grant; at most one bit set, for one cycle.
- `core_key`  out  KEY_W  key for the granted core; valid only while `core_gnt` is nonzero.
- `stop_all`  out  1  abort broadcast to all cores; high in FOUND.
- `found`  out  1  search succeeded; sticky until the next `start` or reset.
- `found_key`  out  KEY_W  winning key; valid while `found`.
- `found_core`  out  IDX_W  index of the winning core.
- `exhausted`  out  1  whole range checked, no match; sticky.
- `busy`  out  1  high in RUN and DRAIN.

## Operation
- Reset: every output is 0, state is IDLE, `next_key` is 0, `outstanding` is 0, RR pointer is 0.
- `next_key` is KEY_W+1 bits wide so that it never wraps. Per-core `outstanding[i]` is set on grant and cleared on `core_done[i]`.
- Each core latches the key it was issued. The scheduler keeps a per-core `issued_key[i]` register so it can report `found_key`.

States:
- IDLE: on `start`, load `next_key`=`key_lo`, `key_hi_q`=`key_hi`, clear `outstanding`, `found` and `exhausted`.
  - If `key_lo` > `key_hi`, go to EXHAUSTED.
  - Otherwise go to RUN.
- RUN: each cycle, the eligible set is `core_req & ~outstanding`. Grant the first eligible core at or after the RR pointer.
  - Register `core_gnt`, `core_key`=`next_key` and `issued_key[i]`.
  - Increment `next_key`. Set the RR pointer to the granted index + 1, modulo NUM_CORES.
  - When the key just issued equals `key_hi_q`, go to DRAIN.
- DRAIN: no grants. When `outstanding` is 0 and no match has occurred, go to EXHAUSTED.
- Any `core_done[i] & core_match[i]` seen in RUN or DRAIN goes to FOUND.
  - Latch `found_key`=`issued_key[i]` and `found_core`=`i`.
  - If several cores match in the same cycle, the lowest index wins.
- FOUND: `stop_all`=1 and `found`=1; no grants. `start` restarts the search as from IDLE.
- EXHAUSTED: `exhausted`=1; no grants. `start` restarts the search.
- `start` is ignored in RUN and DRAIN.
- A `core_done` from a core with `outstanding`=0 is ignored.

## Timing
- Grant latency: `core_req[i]` sampled at edge N produces `core_gnt[i]`/`core_key` during cycle N+1.
- A core holds `core_req` through its grant cycle and drops it the cycle after.
- Throughput is one grant per cycle across the array.
- A core is not re-granted until its `core_done` has been seen.
- Match: `core_done`&`core_match` at edge N puts `found`, `stop_all` and `found_key` high from cycle N+1.
  - In cycle N+1, `core_gnt` is 0; a grant that would otherwise issue is suppressed.
- A match arriving in the same cycle as the last grant still goes to FOUND, not DRAIN.
- `exhausted` rises 1 cycle after the final `core_done` clears `outstanding`.
- Reset asserted mid-search clears all state immediately. Outputs return to their reset values asynchronously.

## Test plan
- Range 0x000010..0x000017, 4 cores always requesting, none match.
  - Required: 8 grants in order to cores 0,1,2,3,0,1,2,3 with keys 0x10..0x17.
  - Required: `exhausted`=1 one cycle after the last `core_done`; `found`=0.
- Same range; core 2 reports a match on key 0x12.
  - Required: `found`=1, `found_key`=0x000012, `found_core`=2, `stop_all`=1 the next cycle.
  - Required: no further grants.
- Cores 1 and 3 match in the same cycle.
  - Required: `found_core`=1 with core 1's issued key.
- `key_lo`=`key_hi`=0x3FFFFF.
  - Required: exactly one grant with key 0x3FFFFF, then DRAIN and EXHAUSTED, with no wrap to 0.
  - Also: `key_lo`=5, `key_hi`=4 gives `exhausted` with zero grants.
- Only core 0 requests, holding `core_req` while busy.
  - Required: no second grant until its `core_done`.
- Reset asserted mid-RUN, then `start` again.
  - Required: all outputs 0 during reset; a clean restart from the new `key_lo`.
